// File: rtl/result_display_sequencer.sv
// Captures the four butterfly result words and steps through them on the board
// display, advancing on each debounced low-then-high cycle of the ReadyIn switch.
module result_display_sequencer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             ReadyIn,
    input  logic             results_valid,
    input  logic [WIDTH-1:0] re_y,
    input  logic [WIDTH-1:0] im_y,
    input  logic [WIDTH-1:0] re_z,
    input  logic [WIDTH-1:0] im_z,
    output logic [WIDTH-1:0] display_word,
    output logic [1:0]       word_sel,
    output logic             disp_valid,
    output logic             busy,
    output logic             seq_done
);

    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        WAIT1 = 2'd2,
        SHOW  = 2'd3
    } state_t;

    logic             sync_p0;
    logic             sync_p1;
    logic             rdy_db;
    logic [CNT_W-1:0] db_cnt;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic             capture;
    logic [WIDTH-1:0] word_q [4];

    logic [WIDTH-1:0] display_nxt;
    logic             disp_valid_nxt;
    logic             busy_nxt;
    logic             seq_done_nxt;

    // Stage p0/p1: two-flop synchronizer for the asynchronous slide switch
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= ReadyIn;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: a new level must persist for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rdy_db <= 1'b0;
            db_cnt <= '0;
        end else if (sync_p1 == rdy_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            rdy_db <= sync_p1;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        capture      = 1'b0;
        seq_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (results_valid) begin
                    capture   = 1'b1;
                    idx_nxt   = 2'd0;
                    state_nxt = ARM;
                end
            end
            // The switch must be seen low before the first word, even if it was already high
            ARM: begin
                if (!rdy_db) begin
                    state_nxt = WAIT1;
                end
            end
            WAIT1: begin
                if (rdy_db) begin
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (!rdy_db) begin
                    if (idx == 2'd3) begin
                        seq_done_nxt = 1'b1;
                        idx_nxt      = 2'd0;
                        state_nxt    = IDLE;
                    end else begin
                        idx_nxt   = idx + 2'd1;
                        state_nxt = WAIT1;
                    end
                end
            end
            default: begin
                idx_nxt   = 2'd0;
                state_nxt = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change on the same edge
        disp_valid_nxt = (state_nxt == SHOW);
        busy_nxt       = (state_nxt != IDLE);
        display_nxt    = disp_valid_nxt ? word_q[idx_nxt] : '0;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 4; i++) begin
                word_q[i] <= '0;
            end
        end else if (capture) begin
            word_q[0] <= re_y;
            word_q[1] <= im_y;
            word_q[2] <= re_z;
            word_q[3] <= im_z;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            display_word <= '0;
            word_sel     <= 2'd0;
            disp_valid   <= 1'b0;
            busy         <= 1'b0;
            seq_done     <= 1'b0;
        end else begin
            display_word <= display_nxt;
            word_sel     <= idx_nxt;
            disp_valid   <= disp_valid_nxt;
            busy         <= busy_nxt;
            seq_done     <= seq_done_nxt;
        end
    end

endmodule

// File: tb/tb_result_display_sequencer.sv
// Bench for result_display_sequencer: directed scenarios plus random switch/result
// activity, every cycle compared against a behavioural reference model.
module tb_result_display_sequencer;

    localparam int WIDTH = 8;
    localparam int DEB   = 4;

    logic             Clock         = 1'b0;
    logic             nReset        = 1'b0;
    logic             ReadyIn       = 1'b0;
    logic             results_valid = 1'b0;
    logic [WIDTH-1:0] re_y          = '0;
    logic [WIDTH-1:0] im_y          = '0;
    logic [WIDTH-1:0] re_z          = '0;
    logic [WIDTH-1:0] im_z          = '0;
    logic [WIDTH-1:0] display_word;
    logic [1:0]       word_sel;
    logic             disp_valid;
    logic             busy;
    logic             seq_done;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    result_display_sequencer #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .Clock         (Clock),
        .nReset        (nReset),
        .ReadyIn       (ReadyIn),
        .results_valid (results_valid),
        .re_y          (re_y),
        .im_y          (im_y),
        .re_z          (re_z),
        .im_z          (im_z),
        .display_word  (display_word),
        .word_sel      (word_sel),
        .disp_valid    (disp_valid),
        .busy          (busy),
        .seq_done      (seq_done)
    );

    // Reference model: switch samples delayed by two clocks, a run-length debounce,
    // and a phase/position walk over the captured words.
    localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_SHOW = 3;
    int m_s1, m_s2, m_db, m_run, m_phase, m_pos, m_done;
    int m_words [4];

    int   seen [$];
    int   done_cnt = 0;
    logic dv_prev  = 1'b0;
    int   last_lat = -1;
    int   exp_seq [4] = '{'h12, 'h34, 'h56, 'h78};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
        m_phase = P_IDLE; m_pos = 0; m_done = 0;
        for (int i = 0; i < 4; i++) m_words[i] = 0;
    endfunction

    function automatic void model_step();
        int db_old;
        db_old = m_db;
        m_done = 0;
        if (m_phase == P_IDLE) begin
            if (results_valid) begin
                m_words[0] = int'(re_y);
                m_words[1] = int'(im_y);
                m_words[2] = int'(re_z);
                m_words[3] = int'(im_z);
                m_pos   = 0;
                m_phase = P_ARM;
            end
        end else if (m_phase == P_ARM) begin
            if (db_old == 0) m_phase = P_WAIT;
        end else if (m_phase == P_WAIT) begin
            if (db_old == 1) m_phase = P_SHOW;
        end else if (db_old == 0) begin
            if (m_pos == 3) begin
                m_done  = 1;
                m_pos   = 0;
                m_phase = P_IDLE;
            end else begin
                m_pos   = m_pos + 1;
                m_phase = P_WAIT;
            end
        end
        if (m_s2 != m_db) begin
            m_run = m_run + 1;
            if (m_run == DEB) begin
                m_db  = m_s2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = ReadyIn ? 1 : 0;
    endfunction

    task automatic check_outputs();
        int exp_disp;
        exp_disp = (m_phase == P_SHOW) ? m_words[m_pos] : 0;
        check_val("display_word", 32'(display_word), exp_disp);
        check_val("word_sel", 32'(word_sel), m_pos);
        check_val("disp_valid", 32'(disp_valid), (m_phase == P_SHOW) ? 1 : 0);
        check_val("busy", 32'(busy), (m_phase != P_IDLE) ? 1 : 0);
        check_val("seq_done", 32'(seq_done), m_done);
        if (disp_valid && !dv_prev) seen.push_back(int'(display_word));
        if (seq_done) done_cnt++;
        dv_prev = disp_valid;
    endtask

    task automatic tick();
        @(posedge Clock);
        if (nReset) model_step();
        else        model_reset();
        @(negedge Clock);
        check_outputs();
    endtask

    task automatic drive_rdy(input logic level, input int cycles);
        ReadyIn  = level;
        last_lat = -1;
        for (int i = 1; i <= cycles; i++) begin
            tick();
            if (level && last_lat < 0 && disp_valid) last_lat = i;
        end
    endtask

    task automatic capture(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        re_y = a; im_y = b; re_z = c; im_z = d;
        results_valid = 1'b1;
        tick();
        results_valid = 1'b0;
    endtask

    task automatic expect_seen(input string tag);
        check_val({tag, "_count"}, seen.size(), 4);
        for (int i = 0; i < 4; i++)
            check_val({tag, "_word"}, (i < seen.size()) ? seen[i] : 32'hDEAD, exp_seq[i]);
    endtask

    task automatic zero_now(input string tag);
        check_val({tag, "_disp"}, 32'(display_word), 0);
        check_val({tag, "_sel"}, 32'(word_sel), 0);
        check_val({tag, "_valid"}, 32'(disp_valid), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_done"}, 32'(seq_done), 0);
    endtask

    initial begin
        model_reset();

        // Reset held while all inputs toggle
        for (int i = 0; i < 6; i++) begin
            ReadyIn       = 1'($urandom_range(0, 1));
            results_valid = 1'($urandom_range(0, 1));
            re_y = 8'($urandom); im_y = 8'($urandom);
            re_z = 8'($urandom); im_z = 8'($urandom);
            tick();
            zero_now("reset");
        end
        ReadyIn = 1'b0; results_valid = 1'b0;
        nReset  = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Full four-word sequence with latency check on every word
        seen.delete(); done_cnt = 0;
        capture(8'h12, 8'h34, 8'h56, 8'h78);
        drive_rdy(1'b0, 10);
        for (int w = 0; w < 4; w++) begin
            drive_rdy(1'b1, 10);
            check_val("word_latency", last_lat, 2 + DEB + 1);
            drive_rdy(1'b0, 10);
        end
        expect_seen("full_seq");
        check_val("seq_done_count", done_cnt, 1);
        check_val("busy_after_seq", 32'(busy), 0);

        // Short glitch while waiting must not show anything
        seen.delete();
        capture(8'h12, 8'h34, 8'h56, 8'h78);
        drive_rdy(1'b0, 10);
        drive_rdy(1'b1, 3);
        drive_rdy(1'b0, 10);
        check_val("glitch_no_show", seen.size(), 0);
        check_val("glitch_busy", 32'(busy), 1);
        for (int w = 0; w < 4; w++) begin
            drive_rdy(1'b1, 10);
            drive_rdy(1'b0, 10);
        end

        // Switch already high when results arrive
        seen.delete();
        drive_rdy(1'b1, 10);
        capture(8'h12, 8'h34, 8'h56, 8'h78);
        drive_rdy(1'b1, 15);
        check_val("high_at_capture_no_show", seen.size(), 0);
        drive_rdy(1'b0, 10);
        drive_rdy(1'b1, 10);
        check_val("high_at_capture_first", (seen.size() > 0) ? seen[0] : 32'hDEAD, 'h12);
        for (int w = 0; w < 3; w++) begin
            drive_rdy(1'b0, 10);
            drive_rdy(1'b1, 10);
        end
        drive_rdy(1'b0, 10);

        // Recapture attempt while showing word 1
        seen.delete();
        capture(8'h12, 8'h34, 8'h56, 8'h78);
        drive_rdy(1'b0, 10);
        drive_rdy(1'b1, 10);
        drive_rdy(1'b0, 10);
        drive_rdy(1'b1, 10);
        check_val("recap_sel", 32'(word_sel), 1);
        capture(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        drive_rdy(1'b0, 10);
        drive_rdy(1'b1, 10);
        drive_rdy(1'b0, 10);
        drive_rdy(1'b1, 10);
        drive_rdy(1'b0, 10);
        expect_seen("recapture");

        // Reset while showing word 2, then restart
        capture(8'h12, 8'h34, 8'h56, 8'h78);
        drive_rdy(1'b0, 10);
        for (int w = 0; w < 3; w++) begin
            drive_rdy(1'b1, 10);
            if (w < 2) drive_rdy(1'b0, 10);
        end
        check_val("pre_reset_sel", 32'(word_sel), 2);
        nReset = 1'b0;
        #1;
        zero_now("mid_reset");
        model_reset();
        ReadyIn = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        nReset = 1'b1;
        seen.delete();
        capture(8'hA5, 8'h5A, 8'hC3, 8'h3C);
        drive_rdy(1'b0, 10);
        drive_rdy(1'b1, 10);
        check_val("restart_first", (seen.size() > 0) ? seen[0] : 32'hDEAD, 'hA5);
        check_val("restart_sel", 32'(word_sel), 0);

        // Random activity against the model
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                nReset  = 1'b0;
                ReadyIn = 1'($urandom_range(0, 1));
                tick();
                tick();
                nReset = 1'b1;
            end else if (r < 20) begin
                capture(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            end else begin
                drive_rdy(~ReadyIn, $urandom_range(1, 14));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
